vx_core_rsp_batcher: RTL and testbench

- Multi-bank, multi-port core-response merger for the shared cache with tag-ID batching.
- Each cycle it picks one tag ID and gathers every pending bank/port response carrying that ID into a single core response beat (tmask + per-lane data).
- Tag selection is round-robin across banks, so a busy low-index bank cannot starve the others.
- Lane collisions inside a batch are deferred, never dropped, and counted. The block sits between the bank array and the core response bus.

---
 rtl/vx_core_rsp_batcher.sv | 272 +++++++++++++++++++++++++++
 tb/tb_vx_core_rsp_batcher.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_core_rsp_batcher.sv
// ---------------------------------------------------------------------------
// vx_core_rsp_batcher
//
// Merges per-bank, per-port cache responses into core response beats.
// Each cycle one leader slot is chosen by scanning banks round-robin
// (starting at rr_ptr) and ports low-to-high. Every pending slot whose
// tag ID matches the leader's ID joins the beat, unless its destination lane
// is already claimed earlier in the scan. In that case the slot stays pending
// for a later beat and the collision is counted.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   per_bank_core_rsp_valid    [NUM_BANKS]   bank presents an entry
//   per_bank_core_rsp_pmask    [NB*NP]       active ports of each entry
//   per_bank_core_rsp_data     [NB*NP*W]     port data
//   per_bank_core_rsp_tid      [NB*NP*TIDW]  destination lane per port
//   per_bank_core_rsp_tag      [NB*NP*TAGW]  tag per port
//   per_bank_core_rsp_ready    [NUM_BANKS]   entry fully consumed (pop)
//   core_rsp_valid/tmask/tag/data/ready      core response beat
//   perf_collisions            saturating count of beats with a collision
//
// Slot index convention: slot = bank*NUM_PORTS + port.
// ---------------------------------------------------------------------------
module vx_core_rsp_batcher #(
    parameter int NUM_REQS         = 4,
    parameter int NUM_BANKS        = 4,
    parameter int NUM_PORTS        = 2,
    parameter int WORD_SIZE        = 4,
    parameter int CORE_TAG_WIDTH   = 8,
    parameter int CORE_TAG_ID_BITS = 2,
    parameter int OUT_REG          = 1,
    parameter int PERF_CTR_BITS    = 16
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic [NUM_BANKS-1:0]                                  per_bank_core_rsp_valid,
    input  logic [NUM_BANKS*NUM_PORTS-1:0]                        per_bank_core_rsp_pmask,
    input  logic [NUM_BANKS*NUM_PORTS*8*WORD_SIZE-1:0]            per_bank_core_rsp_data,
    input  logic [NUM_BANKS*NUM_PORTS*$clog2(NUM_REQS)-1:0]       per_bank_core_rsp_tid,
    input  logic [NUM_BANKS*NUM_PORTS*CORE_TAG_WIDTH-1:0]         per_bank_core_rsp_tag,
    output logic [NUM_BANKS-1:0]                                  per_bank_core_rsp_ready,
    output logic                                                  core_rsp_valid,
    output logic [NUM_REQS-1:0]                                   core_rsp_tmask,
    output logic [CORE_TAG_WIDTH-1:0]                             core_rsp_tag,
    output logic [NUM_REQS*8*WORD_SIZE-1:0]                       core_rsp_data,
    input  logic                                                  core_rsp_ready,
    output logic [PERF_CTR_BITS-1:0]                              perf_collisions
);

    localparam int WORD_W = 8 * WORD_SIZE;
    localparam int TID_W  = $clog2(NUM_REQS);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int NSLOTS = NUM_BANKS * NUM_PORTS;
    localparam int SLOT_W = $clog2(NSLOTS);

    // ------------------------------------------------------------------
    // Slot unpacking
    // ------------------------------------------------------------------
    logic [WORD_W-1:0]           slot_data [NSLOTS];
    logic [TID_W-1:0]            slot_tid  [NSLOTS];
    logic [CORE_TAG_WIDTH-1:0]   slot_tag  [NSLOTS];
    logic [CORE_TAG_ID_BITS-1:0] slot_id   [NSLOTS];
    logic [NSLOTS-1:0]           slot_pend;

    logic [NSLOTS-1:0]           sent_reg;
    logic [NSLOTS-1:0]           sent_next;
    logic [BANK_W-1:0]           rr_ptr_reg;
    logic [PERF_CTR_BITS-1:0]    perf_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NSLOTS; gi++) begin : g_slot
            assign slot_data[gi] = per_bank_core_rsp_data[gi*WORD_W +: WORD_W];
            assign slot_tid[gi]  = per_bank_core_rsp_tid[gi*TID_W +: TID_W];
            assign slot_tag[gi]  = per_bank_core_rsp_tag[gi*CORE_TAG_WIDTH +: CORE_TAG_WIDTH];
            assign slot_id[gi]   = slot_tag[gi][CORE_TAG_ID_BITS-1:0];
            assign slot_pend[gi] = per_bank_core_rsp_valid[gi / NUM_PORTS]
                                 & per_bank_core_rsp_pmask[gi]
                                 & ~sent_reg[gi];
        end
    endgenerate

    // Bank visited at scan position k, counting from the round-robin pointer.
    function automatic logic [BANK_W-1:0] scan_bank(input logic [BANK_W-1:0] rr, input int k);
        int b;
        b = (int'(rr) + k) % NUM_BANKS;
        return BANK_W'(b);
    endfunction

    function automatic logic [SLOT_W-1:0] scan_slot(input logic [BANK_W-1:0] rr, input int k,
                                                   input int p);
        int b;
        b = (int'(rr) + k) % NUM_BANKS;
        return SLOT_W'(b * NUM_PORTS + p);
    endfunction

    // ------------------------------------------------------------------
    // Leader selection: first pending slot in round-robin scan order
    // ------------------------------------------------------------------
    logic                  leader_found;
    logic [SLOT_W-1:0]     leader_slot;
    logic [BANK_W-1:0]     leader_bank;

    always_comb begin
        leader_found = 1'b0;
        leader_slot  = '0;
        leader_bank  = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!leader_found && slot_pend[scan_slot(rr_ptr_reg, k, p)]) begin
                    leader_found = 1'b1;
                    leader_slot  = scan_slot(rr_ptr_reg, k, p);
                    leader_bank  = scan_bank(rr_ptr_reg, k);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Batch gathering. The scan order matches leader selection, so the
    // leader always claims its lane first; later members that hit an
    // already-claimed lane are left pending (collision).
    // ------------------------------------------------------------------
    logic [CORE_TAG_ID_BITS-1:0]       leader_id;
    logic [NUM_REQS-1:0]               lanes_used;
    logic [NSLOTS-1:0]                 claimed;
    logic                              collision;
    logic [NUM_REQS-1:0][WORD_W-1:0]   stage_data;

    assign leader_id = slot_id[leader_slot];

    always_comb begin
        logic [SLOT_W-1:0] s;
        s          = '0;
        lanes_used = '0;
        claimed    = '0;
        collision  = 1'b0;
        stage_data = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                s = scan_slot(rr_ptr_reg, k, p);
                if (leader_found && slot_pend[s] && (slot_id[s] == leader_id)) begin
                    if (lanes_used[slot_tid[s]]) begin
                        collision = 1'b1;
                    end else begin
                        lanes_used[slot_tid[s]] = 1'b1;
                        claimed[s]              = 1'b1;
                        stage_data[slot_tid[s]] = slot_data[s];
                    end
                end
            end
        end
    end

    logic                      stage_valid;
    logic                      stage_ready;
    logic [NUM_REQS-1:0]       stage_tmask;
    logic [CORE_TAG_WIDTH-1:0] stage_tag;
    logic                      fire;

    assign stage_valid = |slot_pend;
    assign stage_tmask = lanes_used;
    assign stage_tag   = slot_tag[leader_slot];
    assign fire        = stage_valid & stage_ready;

    // ------------------------------------------------------------------
    // Per-bank completion and sent-mask bookkeeping
    // ------------------------------------------------------------------
    logic [NSLOTS-1:0]    sent_reg_next;
    logic [NUM_BANKS-1:0] bank_done;

    assign sent_next = sent_reg | claimed;

    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            // A bank pops only on a beat it contributed to and once every
            // active port has been delivered.
            assign bank_done[gi] = fire
                                 & (|claimed[gi*NUM_PORTS +: NUM_PORTS])
                                 & (sent_next[gi*NUM_PORTS +: NUM_PORTS]
                                    == per_bank_core_rsp_pmask[gi*NUM_PORTS +: NUM_PORTS]);

            assign sent_reg_next[gi*NUM_PORTS +: NUM_PORTS] =
                !fire         ? sent_reg[gi*NUM_PORTS +: NUM_PORTS] :
                bank_done[gi] ? {NUM_PORTS{1'b0}} :
                                sent_next[gi*NUM_PORTS +: NUM_PORTS];

            assign per_bank_core_rsp_ready[gi] = bank_done[gi];

            // An entry with no active ports could never be popped.
            a_pmask_nonzero : assert property (@(posedge clk) disable iff (reset)
                per_bank_core_rsp_valid[gi] |-> (|per_bank_core_rsp_pmask[gi*NUM_PORTS +: NUM_PORTS]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sent_reg   <= '0;
            rr_ptr_reg <= '0;
            perf_reg   <= '0;
        end else begin
            sent_reg <= sent_reg_next;
            if (fire) begin
                rr_ptr_reg <= (leader_bank == BANK_W'(NUM_BANKS - 1)) ? '0
                                                                       : leader_bank + BANK_W'(1);
            end
            if (fire && collision && (perf_reg != {PERF_CTR_BITS{1'b1}})) begin
                perf_reg <= perf_reg + PERF_CTR_BITS'(1);
            end
        end
    end

    assign perf_collisions = perf_reg;

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_skid
            // Two entries let the batcher keep firing every cycle while a
            // beat is being accepted, with one cycle of latency.
            logic [NUM_REQS-1:0]        buf_tmask [2];
            logic [CORE_TAG_WIDTH-1:0]  buf_tag   [2];
            logic [NUM_REQS*WORD_W-1:0] buf_data  [2];
            logic                       wr_ptr_reg;
            logic                       rd_ptr_reg;
            logic [1:0]                 count_reg;
            logic                       push;
            logic                       pop;

            assign push        = fire;
            assign pop         = (count_reg != 2'd0) & core_rsp_ready;
            assign stage_ready = (count_reg != 2'd2);

            always_ff @(posedge clk) begin
                if (push) begin
                    buf_tmask[wr_ptr_reg] <= stage_tmask;
                    buf_tag[wr_ptr_reg]   <= stage_tag;
                    buf_data[wr_ptr_reg]  <= stage_data;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr_reg <= 1'b0;
                    rd_ptr_reg <= 1'b0;
                    count_reg  <= 2'd0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= ~wr_ptr_reg;
                    end
                    if (pop) begin
                        rd_ptr_reg <= ~rd_ptr_reg;
                    end
                    count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
                end
            end

            assign core_rsp_valid = (count_reg != 2'd0);
            assign core_rsp_tmask = buf_tmask[rd_ptr_reg];
            assign core_rsp_tag   = buf_tag[rd_ptr_reg];
            assign core_rsp_data  = buf_data[rd_ptr_reg];
        end else begin : g_pass
            assign stage_ready    = core_rsp_ready;
            assign core_rsp_valid = stage_valid;
            assign core_rsp_tmask = stage_tmask;
            assign core_rsp_tag   = stage_tag;
            assign core_rsp_data  = stage_data;
        end
    endgenerate

endmodule

// File: tb/tb_vx_core_rsp_batcher.sv
// ---------------------------------------------------------------------------
// Directed bench for vx_core_rsp_batcher (NB=4, NP=2, NR=4, ID_BITS=2).
// dut0 uses the combinational output path, dut1 the two-entry skid buffer.
// Inputs change #1 after a rising edge; outputs are checked on falling edges.
// ---------------------------------------------------------------------------
module tb_vx_core_rsp_batcher;

    localparam int NB = 4;
    localparam int NP = 2;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // dut0 (OUT_REG=0)
    logic [NB-1:0]                  a_valid;
    logic [NB-1:0][NP-1:0]          a_pmask;
    logic [NB-1:0][NP-1:0][31:0]    a_data;
    logic [NB-1:0][NP-1:0][1:0]     a_tid;
    logic [NB-1:0][NP-1:0][7:0]     a_tag;
    logic [NB-1:0]                  a_ready;
    logic                           c0_valid;
    logic [NR-1:0]                  c0_tmask;
    logic [7:0]                     c0_tag;
    logic [NR*32-1:0]               c0_data;
    logic                           c0_ready;
    logic [15:0]                    c0_perf;

    // dut1 (OUT_REG=1)
    logic [NB-1:0]                  b_valid;
    logic [NB-1:0][NP-1:0]          b_pmask;
    logic [NB-1:0][NP-1:0][31:0]    b_data;
    logic [NB-1:0][NP-1:0][1:0]     b_tid;
    logic [NB-1:0][NP-1:0][7:0]     b_tag;
    logic [NB-1:0]                  b_ready;
    logic                           c1_valid;
    logic [NR-1:0]                  c1_tmask;
    logic [7:0]                     c1_tag;
    logic [NR*32-1:0]               c1_data;
    logic                           c1_ready;
    logic [15:0]                    c1_perf;

    vx_core_rsp_batcher #(.OUT_REG(0)) dut0 (
        .clk                     (clk),
        .reset                   (reset),
        .per_bank_core_rsp_valid (a_valid),
        .per_bank_core_rsp_pmask (a_pmask),
        .per_bank_core_rsp_data  (a_data),
        .per_bank_core_rsp_tid   (a_tid),
        .per_bank_core_rsp_tag   (a_tag),
        .per_bank_core_rsp_ready (a_ready),
        .core_rsp_valid          (c0_valid),
        .core_rsp_tmask          (c0_tmask),
        .core_rsp_tag            (c0_tag),
        .core_rsp_data           (c0_data),
        .core_rsp_ready          (c0_ready),
        .perf_collisions         (c0_perf)
    );

    vx_core_rsp_batcher #(.OUT_REG(1)) dut1 (
        .clk                     (clk),
        .reset                   (reset),
        .per_bank_core_rsp_valid (b_valid),
        .per_bank_core_rsp_pmask (b_pmask),
        .per_bank_core_rsp_data  (b_data),
        .per_bank_core_rsp_tid   (b_tid),
        .per_bank_core_rsp_tag   (b_tag),
        .per_bank_core_rsp_ready (b_ready),
        .core_rsp_valid          (c1_valid),
        .core_rsp_tmask          (c1_tmask),
        .core_rsp_tag            (c1_tag),
        .core_rsp_data           (c1_data),
        .core_rsp_ready          (c1_ready),
        .perf_collisions         (c1_perf)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [127:0] lane(input int l, input logic [31:0] d);
        logic [127:0] v;
        v = 128'(d);
        return v << (32 * l);
    endfunction

    task automatic clear_a();
        a_valid = '0; a_pmask = '0; a_data = '0; a_tid = '0; a_tag = '0;
    endtask

    task automatic set_a(input int b, input int p, input logic [1:0] tid,
                         input logic [7:0] tag, input logic [31:0] d);
        a_valid[b]    = 1'b1;
        a_pmask[b][p] = 1'b1;
        a_tid[b][p]   = tid;
        a_tag[b][p]   = tag;
        a_data[b][p]  = d;
    endtask

    task automatic present_b(input int i);
        b_valid[0]    = 1'b1;
        b_pmask[0]    = 2'b01;
        b_tid[0][0]   = 2'(i % 4);
        b_tag[0][0]   = 8'(i);
        b_data[0][0]  = 32'hD0 + 32'(i);
    endtask

    // Hard stop in case something hangs despite the bounded loops.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int gap;
        int serves;
        int idx;
        int got;
        int pops;
        logic popped;

        reset = 1'b1;
        clear_a();
        b_valid = '0; b_pmask = '0; b_data = '0; b_tid = '0; b_tag = '0;
        c0_ready = 1'b1;
        c1_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // ---- reset state ----
        @(negedge clk);
        chk("rst_valid0", 128'(c0_valid), 128'(1'b0));
        chk("rst_ready0", 128'(a_ready), 128'(4'b0000));
        chk("rst_perf0",  128'(c0_perf), 128'(16'd0));
        chk("rst_valid1", 128'(c1_valid), 128'(1'b0));
        chk("rst_ready1", 128'(b_ready), 128'(4'b0000));
        $display("txn reset: checked idle outputs");

        // ---- single entry: bank2, tids 0/3, tag 0x41 ----
        @(posedge clk); #1;
        clear_a();
        set_a(2, 0, 2'd0, 8'h41, 32'hA0);
        set_a(2, 1, 2'd3, 8'h41, 32'hA3);
        @(negedge clk);
        chk("single_valid", 128'(c0_valid), 128'(1'b1));
        chk("single_tmask", 128'(c0_tmask), 128'(4'b1001));
        chk("single_tag",   128'(c0_tag),   128'(8'h41));
        chk("single_data",  c0_data, lane(0, 32'hA0) | lane(3, 32'hA3));
        chk("single_ready", 128'(a_ready), 128'(4'b0100));
        $display("txn single: tmask=%b tag=%h ready=%b", c0_tmask, c0_tag, a_ready);

        // ---- batching: rr_ptr is now 3, so bank3 leads the ID=1 batch ----
        @(posedge clk); #1;
        clear_a();
        set_a(0, 0, 2'd1, 8'h05, 32'hB0);
        set_a(3, 0, 2'd2, 8'h15, 32'hB3);
        set_a(1, 0, 2'd0, 8'h02, 32'hB1);
        @(negedge clk);
        chk("batch1_tmask", 128'(c0_tmask), 128'(4'b0110));
        chk("batch1_tag",   128'(c0_tag),   128'(8'h15));
        chk("batch1_data",  c0_data, lane(1, 32'hB0) | lane(2, 32'hB3));
        chk("batch1_ready", 128'(a_ready), 128'(4'b1001));
        $display("txn batch1: tmask=%b tag=%h ready=%b", c0_tmask, c0_tag, a_ready);
        @(posedge clk); #1;
        a_valid[0] = 1'b0; a_pmask[0] = '0;
        a_valid[3] = 1'b0; a_pmask[3] = '0;
        @(negedge clk);
        chk("batch2_tmask", 128'(c0_tmask), 128'(4'b0001));
        chk("batch2_tag",   128'(c0_tag),   128'(8'h02));
        chk("batch2_data",  c0_data, lane(0, 32'hB1));
        chk("batch2_ready", 128'(a_ready), 128'(4'b0010));
        $display("txn batch2: tmask=%b tag=%h ready=%b", c0_tmask, c0_tag, a_ready);

        // ---- collision: banks 0 and 1, both ID 0, both tid 0 ----
        @(posedge clk); #1;
        clear_a();
        set_a(0, 0, 2'd0, 8'h10, 32'hC0);
        set_a(1, 0, 2'd0, 8'h20, 32'hC1);
        @(negedge clk);
        chk("coll1_tmask", 128'(c0_tmask), 128'(4'b0001));
        chk("coll1_tag",   128'(c0_tag),   128'(8'h10));
        chk("coll1_data",  c0_data, lane(0, 32'hC0));
        chk("coll1_ready", 128'(a_ready), 128'(4'b0001));
        $display("txn coll1: tag=%h ready=%b", c0_tag, a_ready);
        @(posedge clk); #1;
        chk("coll1_perf", 128'(c0_perf), 128'(16'd1));
        a_valid[0] = 1'b0; a_pmask[0] = '0;
        @(negedge clk);
        chk("coll2_tag",   128'(c0_tag), 128'(8'h20));
        chk("coll2_data",  c0_data, lane(0, 32'hC1));
        chk("coll2_ready", 128'(a_ready), 128'(4'b0010));
        chk("coll2_perf",  128'(c0_perf), 128'(16'd1));
        $display("txn coll2: tag=%h ready=%b perf=%0d", c0_tag, a_ready, c0_perf);

        // ---- fairness: bank0 always ID0, bank1 ID1; rr_ptr starts at 2 ----
        @(posedge clk); #1;
        clear_a();
        set_a(0, 0, 2'd0, 8'h00, 32'hD0);
        set_a(1, 0, 2'd1, 8'h01, 32'hD1);
        gap = 0;
        serves = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (c0_valid) begin
                gap++;
                if (a_ready[1]) begin
                    serves++;
                    chk("fair_gap", 128'(gap <= 2), 128'(1'b1));
                    $display("txn fair: bank1 served after %0d fires", gap);
                    gap = 0;
                end
            end
        end
        chk("fair_serves", 128'(serves), 128'(50));

        // ---- reset mid-batch: bank0 two ports on the same lane ----
        @(posedge clk); #1;
        clear_a();
        set_a(0, 0, 2'd0, 8'h00, 32'hE0);
        set_a(0, 1, 2'd0, 8'h00, 32'hE1);
        @(negedge clk);
        chk("mid_data",  c0_data, lane(0, 32'hE0));
        chk("mid_ready", 128'(a_ready), 128'(4'b0000));
        @(posedge clk); #1;
        chk("mid_perf", 128'(c0_perf), 128'(16'd2));
        reset = 1'b1;
        clear_a();
        @(posedge clk); #1;
        chk("rstmid_perf",  128'(c0_perf), 128'(16'd0));
        chk("rstmid_valid", 128'(c0_valid), 128'(1'b0));
        reset = 1'b0;
        set_a(0, 0, 2'd0, 8'h00, 32'hE0);
        set_a(0, 1, 2'd0, 8'h00, 32'hE1);
        @(negedge clk);
        chk("rerun1_data",  c0_data, lane(0, 32'hE0));
        chk("rerun1_ready", 128'(a_ready), 128'(4'b0000));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rerun2_data",  c0_data, lane(0, 32'hE1));
        chk("rerun2_ready", 128'(a_ready), 128'(4'b0001));
        chk("rerun2_perf",  128'(c0_perf), 128'(16'd1));
        $display("txn reset_mid: data=%h ready=%b perf=%0d", c0_data[31:0], a_ready, c0_perf);
        @(posedge clk); #1;
        clear_a();

        // ---- backpressure through the skid buffer (dut1) ----
        idx = 0;
        got = 0;
        pops = 0;
        present_b(0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            c1_ready = (cyc >= 5);
            @(negedge clk);
            if (c1_valid && c1_ready) begin
                if (got < 6) begin
                    chk("bp_tag",   128'(c1_tag), 128'(8'(got)));
                    chk("bp_tmask", 128'(c1_tmask), 128'(4'b0001 << (got % 4)));
                    chk("bp_data",  c1_data, lane(got % 4, 32'hD0 + 32'(got)));
                end
                $display("txn bp: beat %0d tag=%h tmask=%b", got, c1_tag, c1_tmask);
                got++;
            end
            popped = b_ready[0];
            if (popped) pops++;
            if (cyc == 4) begin
                chk("bp_held_pops",  128'(pops), 128'(2));
                chk("bp_held_valid", 128'(c1_valid), 128'(1'b1));
                chk("bp_held_ready", 128'(b_ready), 128'(4'b0000));
            end
            @(posedge clk); #1;
            if (popped) begin
                idx++;
                if (idx < 6) present_b(idx);
                else begin
                    b_valid = '0;
                    b_pmask = '0;
                end
            end
        end
        chk("bp_beats", 128'(got), 128'(6));
        chk("bp_pops",  128'(pops), 128'(6));
        @(negedge clk);
        chk("bp_drained", 128'(c1_valid), 128'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
